// File: rtl/btle_synth_ctrl.sv
// BLE channel -> synthesizer programming controller.
// Maps the selected channel to MHz, shifts a 24-bit SPI frame, waits for settling, flags LO ready.
module btle_synth_ctrl #(
  parameter int          CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int          SPI_DIV                  = 4,
  parameter int          SETTLE_CYCLES            = 640,
  parameter logic [7:0]  REG_ADDR                 = 8'h10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
  input  logic                                tx_sel,
  output logic                                spi_cs_n,
  output logic                                spi_sclk,
  output logic                                spi_mosi,
  output logic                                synth_busy,
  output logic                                synth_ready,
  output logic                                chan_err,
  output logic [11:0]                         rf_freq_mhz
);

  localparam int W       = CHANNEL_NUMBER_BIT_WIDTH;
  localparam int CNT_MAX = (SETTLE_CYCLES > SPI_DIV) ? SETTLE_CYCLES : SPI_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(SPI_DIV - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_SETTLE
  } state_t;

  function automatic logic [11:0] chan_to_mhz(input logic [W-1:0] ch);
    logic [11:0] k;
    k = 12'(ch);
    if (k <= 12'd10)      return 12'd2404 + (k << 1);
    else if (k <= 12'd36) return 12'd2428 + ((k - 12'd11) << 1);
    else if (k == 12'd37) return 12'd2402;
    else if (k == 12'd38) return 12'd2426;
    else if (k == 12'd39) return 12'd2480;
    else                  return 12'd0;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [23:0]      shift_q, shift_d;
  logic             cur_tx_q, cur_tx_d;
  logic [W-1:0]     cur_ch_q, cur_ch_d;
  logic [11:0]      freq_q, freq_d;
  logic             prog_tx_q, prog_tx_d;
  logic [W-1:0]     prog_ch_q, prog_ch_d;
  logic             pending_q, pending_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [11:0]      rf_q, rf_d;

  logic [W-1:0] sel_ch;
  logic         tgt_valid;

  assign sel_ch    = tx_sel ? tx_channel_number : rx_channel_number;
  assign chan_err  = (sel_ch > W'(39));
  assign tgt_valid = !chan_err;

  // NOTE: every *_d gets its current value first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cur_tx_d  = cur_tx_q;
    cur_ch_d  = cur_ch_q;
    freq_d    = freq_q;
    prog_tx_d = prog_tx_q;
    prog_ch_d = prog_ch_q;
    pending_d = pending_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    rf_d      = rf_q;

    unique case (state_q)
      S_IDLE: begin
        if (!tgt_valid) begin
          ready_d   = 1'b0;
          pending_d = 1'b1;  // force a re-send once the index is valid again
        end else if (pending_q || (tx_sel != prog_tx_q) || (sel_ch != prog_ch_q)) begin
          cur_tx_d = tx_sel;
          cur_ch_d = sel_ch;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          state_d  = S_MAP;
        end
      end

      S_MAP: begin
        freq_d    = chan_to_mhz(cur_ch_q);
        shift_d   = {REG_ADDR, 3'b000, cur_tx_q, chan_to_mhz(cur_ch_q)};
        pending_d = 1'b0;
        cs_n_d    = 1'b0;
        sclk_d    = 1'b0;
        mosi_d    = REG_ADDR[7];
        cnt_d     = '0;
        state_d   = S_CS_SETUP;
      end

      S_CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = S_CS_HOLD;
            end else begin
              bit_d   = bit_q + 5'd1;
              shift_d = {shift_q[22:0], 1'b0};
              mosi_d  = shift_q[22];
            end
          end
        end
      end

      S_CS_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d     = '0;
          busy_d    = 1'b0;
          prog_tx_d = cur_tx_q;
          prog_ch_d = cur_ch_q;
          rf_d      = freq_q;
          // A selection that moved mid-sequence is left for IDLE to re-program.
          ready_d   = tgt_valid && (tx_sel == cur_tx_q) && (sel_ch == cur_ch_q);
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cur_tx_q  <= 1'b0;
      cur_ch_q  <= '0;
      freq_q    <= '0;
      prog_tx_q <= 1'b0;
      prog_ch_q <= '0;
      pending_q <= 1'b1;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      rf_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cur_tx_q  <= cur_tx_d;
      cur_ch_q  <= cur_ch_d;
      freq_q    <= freq_d;
      prog_tx_q <= prog_tx_d;
      prog_ch_q <= prog_ch_d;
      pending_q <= pending_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      rf_q      <= rf_d;
    end
  end

  assign spi_cs_n    = cs_n_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign synth_busy  = busy_q;
  assign synth_ready = ready_q;
  assign rf_freq_mhz = rf_q;

endmodule

// File: tb/tb_btle_synth_ctrl.sv
// Directed bench for btle_synth_ctrl with SPI_DIV=1, SETTLE_CYCLES=4.
// A passive SPI monitor captures each frame; scenario tasks compare against hand-computed values.
module tb_btle_synth_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  tx_channel_number = 6'd0;
  logic [5:0]  rx_channel_number = 6'd37;
  logic        tx_sel = 1'b0;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        synth_busy, synth_ready, chan_err;
  logic [11:0] rf_freq_mhz;

  int n_vec = 0;
  int n_err = 0;

  btle_synth_ctrl #(
    .CHANNEL_NUMBER_BIT_WIDTH(6),
    .SPI_DIV(1),
    .SETTLE_CYCLES(4),
    .REG_ADDR(8'h10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_channel_number(tx_channel_number),
    .rx_channel_number(rx_channel_number),
    .tx_sel(tx_sel),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .synth_busy(synth_busy),
    .synth_ready(synth_ready),
    .chan_err(chan_err),
    .rf_freq_mhz(rf_freq_mhz)
  );

  always #5 clk = ~clk;

  // SPI monitor, sampled on the falling clk edge.
  logic [23:0] cap = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          edges_cur = 0;
  int          low_cur = 0;
  int          cs_falls = 0;
  int          cyc = 0;
  int          last_fall = 0;
  int          last_rise = 0;
  logic [23:0] frame_q[$];
  int          edge_q[$];
  int          low_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!spi_cs_n && prev_cs) begin
      edges_cur <= 0;
      low_cur   <= 1;
      cap       <= '0;
      cs_falls  <= cs_falls + 1;
      last_fall <= cyc;
    end else if (!spi_cs_n) begin
      low_cur <= low_cur + 1;
      if (spi_sclk && !prev_sclk) begin
        cap       <= {cap[22:0], spi_mosi};
        edges_cur <= edges_cur + 1;
      end
    end
    if (spi_cs_n && !prev_cs) begin
      frame_q.push_back(cap);
      edge_q.push_back(edges_cur);
      low_q.push_back(low_cur);
      last_rise <= cyc;
    end
    prev_cs   <= spi_cs_n;
    prev_sclk <= spi_sclk;
  end

  function automatic logic [23:0] pop_frame();
    if (frame_q.size() == 0) return 24'hxxxxxx;
    void'(edge_q.pop_front());
    void'(low_q.pop_front());
    return frame_q.pop_front();
  endfunction

  function automatic int head_edges();
    if (edge_q.size() == 0) return -1;
    return edge_q[0];
  endfunction

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      if (synth_ready && !synth_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int fall_at, rdy_at, e, l;
    logic [23:0] fr;
    rst = 1'b1; tx_sel = 1'b0; rx_channel_number = 6'd37; tx_channel_number = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({spi_cs_n, spi_sclk, spi_mosi} !== 3'b100) begin n_err++; $display("FAIL reset_spi: got %b want 100", {spi_cs_n, spi_sclk, spi_mosi}); end
    n_vec++; if ({synth_busy, synth_ready} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {synth_busy, synth_ready}); end
    n_vec++; if (rf_freq_mhz !== 12'd0) begin n_err++; $display("FAIL reset_rf: got %0d want 0", rf_freq_mhz); end
    @(negedge clk);
    rst = 1'b0;
    fall_at = -1; rdy_at = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_vec++; if ({synth_busy, synth_ready, spi_cs_n} !== 3'b101) begin n_err++; $display("FAIL first_edge: got busy,ready,cs_n=%b want 101", {synth_busy, synth_ready, spi_cs_n}); end
      end
      if (fall_at < 0 && !spi_cs_n) fall_at = c;
      if (synth_ready) begin rdy_at = c; break; end
    end
    n_vec++; if (fall_at != 2) begin n_err++; $display("FAIL cs_fall_latency: got %0d want 2", fall_at); end
    n_vec++; if (rdy_at != 56) begin n_err++; $display("FAIL ready_latency: got %0d want 56", rdy_at); end
    e = head_edges();
    l = (low_q.size() > 0) ? low_q[0] : -1;
    fr = pop_frame();
    n_vec++; if (fr !== 24'h100962) begin n_err++; $display("FAIL frame_rx37: got %h want 100962", fr); end
    n_vec++; if (e != 24) begin n_err++; $display("FAIL sclk_edges: got %0d want 24", e); end
    n_vec++; if (l != 50) begin n_err++; $display("FAIL cs_low_cycles: got %0d want 50", l); end
    n_vec++; if (rf_freq_mhz !== 12'd2402) begin n_err++; $display("FAIL rf_rx37: got %0d want 2402", rf_freq_mhz); end
  endtask

  task automatic test_steady();
    int falls0, dropped;
    falls0 = cs_falls; dropped = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!synth_ready) dropped++;
    end
    n_vec++; if (dropped != 0) begin n_err++; $display("FAIL steady_ready: got %0d low cycles want 0", dropped); end
    n_vec++; if (cs_falls != falls0) begin n_err++; $display("FAIL steady_no_frame: got %0d frames want 0", cs_falls - falls0); end
  endtask

  task automatic test_tx_switch();
    int falls0;
    bit ok;
    logic [23:0] fr;
    falls0 = cs_falls;
    @(negedge clk); tx_channel_number = 6'd13;
    repeat (20) @(negedge clk);
    n_vec++; if (cs_falls != falls0 || synth_ready !== 1'b1) begin n_err++; $display("FAIL unselected_tx_change: got frames=%0d ready=%b want 0,1", cs_falls - falls0, synth_ready); end
    tx_sel = 1'b1;
    wait_ready(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL tx_ready_timeout: got no ready want ready"); end
    fr = pop_frame();
    n_vec++; if (fr !== 24'h101980) begin n_err++; $display("FAIL frame_tx13: got %h want 101980", fr); end
    n_vec++; if (rf_freq_mhz !== 12'd2432) begin n_err++; $display("FAIL rf_tx13: got %0d want 2432", rf_freq_mhz); end
  endtask

  task automatic test_change_during_shift();
    int r1, nfr, waited;
    bit rdy;
    logic [23:0] f1, f2;
    @(negedge clk); tx_sel = 1'b0;
    waited = 0;
    while (!(!spi_cs_n && edges_cur >= 5) && waited < 100) begin @(negedge clk); waited++; end
    n_vec++; if (waited >= 100) begin n_err++; $display("FAIL shift_reach_timeout: got no SHIFT want SHIFT"); end
    rx_channel_number = 6'd0;
    r1 = -1; rdy = 1'b0; nfr = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (r1 < 0 && frame_q.size() == 1) r1 = last_rise;
      if (synth_ready) begin rdy = 1'b1; nfr = frame_q.size(); break; end
    end
    n_vec++; if (!rdy || nfr != 2) begin n_err++; $display("FAIL ready_after_second: got ready=%b frames=%0d want 1,2", rdy, nfr); end
    n_vec++; if (last_fall - r1 != 6) begin n_err++; $display("FAIL refire_gap: got %0d want 6", last_fall - r1); end
    f1 = pop_frame();
    f2 = pop_frame();
    n_vec++; if (f1 !== 24'h100962) begin n_err++; $display("FAIL frame_unaltered: got %h want 100962", f1); end
    n_vec++; if (f2 !== 24'h100964) begin n_err++; $display("FAIL frame_rx0: got %h want 100964", f2); end
    n_vec++; if (rf_freq_mhz !== 12'd2404) begin n_err++; $display("FAIL rf_rx0: got %0d want 2404", rf_freq_mhz); end
  endtask

  task automatic test_invalid();
    int falls0;
    bit ok;
    logic [23:0] fr;
    falls0 = cs_falls;
    @(negedge clk); rx_channel_number = 6'd40;
    #1;
    n_vec++; if (chan_err !== 1'b1) begin n_err++; $display("FAIL chan_err_40: got %b want 1", chan_err); end
    @(negedge clk); rx_channel_number = 6'd45;
    #1;
    n_vec++; if (chan_err !== 1'b1) begin n_err++; $display("FAIL chan_err_45: got %b want 1", chan_err); end
    repeat (50) @(negedge clk);
    n_vec++; if ({synth_ready, synth_busy} !== 2'b00) begin n_err++; $display("FAIL invalid_flags: got ready,busy=%b want 00", {synth_ready, synth_busy}); end
    n_vec++; if (cs_falls != falls0) begin n_err++; $display("FAIL invalid_no_frame: got %0d frames want 0", cs_falls - falls0); end
    n_vec++; if (rf_freq_mhz !== 12'd2404) begin n_err++; $display("FAIL invalid_rf_hold: got %0d want 2404", rf_freq_mhz); end
    rx_channel_number = 6'd0;  // same as the programmed target
    wait_ready(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL resend_timeout: got no ready want ready"); end
    fr = pop_frame();
    n_vec++; if (fr !== 24'h100964) begin n_err++; $display("FAIL frame_resend: got %h want 100964", fr); end
    n_vec++; if (chan_err !== 1'b0) begin n_err++; $display("FAIL chan_err_0: got %b want 0", chan_err); end
  endtask

  task automatic test_map_edges();
    logic [5:0]  chs [5] = '{6'd39, 6'd10, 6'd11, 6'd36, 6'd38};
    logic [11:0] mhz [5] = '{12'd2480, 12'd2424, 12'd2428, 12'd2478, 12'd2426};
    bit ok;
    logic [23:0] fr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rx_channel_number = chs[i];
      wait_ready(300, ok);
      fr = pop_frame();
      n_vec++; if (!ok || fr !== {8'h10, 4'h0, mhz[i]}) begin n_err++; $display("FAIL map_ch%0d: got ok=%b frame=%h want frame=%h", chs[i], ok, fr, {8'h10, 4'h0, mhz[i]}); end
      n_vec++; if (rf_freq_mhz !== mhz[i]) begin n_err++; $display("FAIL rf_ch%0d: got %0d want %0d", chs[i], rf_freq_mhz, mhz[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited, e;
    bit ok;
    logic [23:0] fr;
    @(negedge clk); rx_channel_number = 6'd20;
    waited = 0;
    while (!(!spi_cs_n && edges_cur >= 10) && waited < 100) begin @(negedge clk); waited++; end
    n_vec++; if (waited >= 100) begin n_err++; $display("FAIL bit10_timeout: got no bit 10 want bit 10"); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({spi_cs_n, spi_sclk, spi_mosi, synth_busy, synth_ready} !== 5'b10000) begin n_err++; $display("FAIL midreset_outputs: got %b want 10000", {spi_cs_n, spi_sclk, spi_mosi, synth_busy, synth_ready}); end
    n_vec++; if (rf_freq_mhz !== 12'd0) begin n_err++; $display("FAIL midreset_rf: got %0d want 0", rf_freq_mhz); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    frame_q.delete(); edge_q.delete(); low_q.delete();
    wait_ready(300, ok);
    e = head_edges();
    fr = pop_frame();
    n_vec++; if (!ok || fr !== 24'h10098E) begin n_err++; $display("FAIL frame_after_reset: got ok=%b frame=%h want 10098e", ok, fr); end
    n_vec++; if (e != 24) begin n_err++; $display("FAIL edges_after_reset: got %0d want 24", e); end
    n_vec++; if (rf_freq_mhz !== 12'd2446) begin n_err++; $display("FAIL rf_after_reset: got %0d want 2446", rf_freq_mhz); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_steady();
    test_tx_switch();
    test_change_during_shift();
    test_invalid();
    test_map_edges();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
